out_mem_ctrl: RTL and testbench
===============================

# out_mem_ctrl

Sequencer for the per-filter output word memory: accepts result bytes from the processing element over a valid/ready stream and packs four per 32-bit word (offset 0 = bits 31:24). Issues filter-block loads from the filter file on request and triggers the final output-file dump. Owns every control, address, offset and data input of the memory, so no other block drives it directly.

## Interface
- DEPTH, 128, memory words; addresses 0..DEPTH-1
- FILTER_WORDS, 16, words per filter-block load (memory loads M..M+FILTER_WORDS-1)
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a layer when in IDLE, ignored elsewhere
- num_bytes  in  16  result bytes in this layer; sampled on start
- res_valid  in  1  result byte valid
- res_data  in  8  result byte
- res_ready  out  1  byte accepted when res_valid && res_ready
- filt_req  in  1  level; request a filter-block load
- filt_base  in  8  base word for the load; sampled when the request is granted
- filt_ack  out  1  one-cycle pulse when the load command is issued
- host_rd  in  1  readback request, honoured only in IDLE
- host_addr  in  8  readback word address
- mem_write, mem_read, mem_writeOut, mem_load  out  1 each  memory commands
- mem_address  out  8  word address
- mem_M  out  8  filter-load base
- mem_offset  out  2  byte lane
- mem_in  out  8  byte to write
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at layer end
- overflow  out  1  sticky; set on a store attempt past word DEPTH-1; cleared by start

## Operation
- States: IDLE, STORE, PAD (macro only), FILT, DUMP, DONE.
- IDLE: res_ready=0. mem_load=host_rd and mem_address=host_addr, both combinational; all other commands 0. start moves to STORE, or to DUMP if num_bytes==0. start also clears the byte counter, word pointer, offset and overflow.
- STORE: res_ready=1 unless filt_req=1 or overflow=1.
  - Each accepted byte registers mem_write=1, mem_address=word pointer, mem_offset=offset, mem_in=res_data for the next cycle.
  - After each accepted byte, offset increments; the word pointer increments when offset wraps 3→0.
  - If the word pointer is already DEPTH when a byte arrives, the byte is not accepted and overflow is set. Stay in STORE until the byte counter reaches num_bytes; in practice the layer stalls.
  - When the counter reaches num_bytes, go to PAD (macro defined and offset≠0) or DUMP.
- Arbitration: filt_req has strict priority over results. In STORE with filt_req=1, res_ready drops in the same cycle (combinational) and the next state is FILT. Any byte already registered completes its write.
- FILT: single cycle. mem_read=1, mem_M=sampled filt_base, filt_ack=1. Return to STORE; from IDLE, filt_req is not serviced.
- DUMP: single cycle, mem_writeOut=1, then DONE.
- DONE: single cycle, done=1, then IDLE.
- Mutual exclusion: at most one of mem_write, mem_read, mem_writeOut is high in any cycle. mem_load is 0 outside IDLE.
- Reset: all outputs 0, state IDLE, counters 0, overflow 0. Reset mid-layer aborts with no dump.

## Timing
- Accepted byte to mem_write: 1 cycle.
- filt_req (in STORE) to filt_ack/mem_read: 1 cycle.
- Last accepted byte to mem_writeOut: 2 cycles without padding. Each pad byte adds 1 cycle.
- mem_writeOut to done: 1 cycle.
- start to first res_ready: 1 cycle.

## Configuration
- OUT_MEM_CTRL_ZERO_PAD_EN defined: when the last byte leaves offset≠0, PAD writes 8'h00 to each remaining lane of the current word, one lane per cycle, before DUMP.
- Not defined: PAD does not exist; unwritten lanes of the last word keep their prior content.

## Test plan
- num_bytes=8, bytes 11..18 back-to-back:
  - mem_write on 8 consecutive cycles.
  - Addresses 0,0,0,0,1,1,1,1; offsets 0,1,2,3,0,1,2,3.
  - mem_writeOut 2 cycles after the last byte; done 1 cycle later.
- num_bytes=6 with the macro: writes lanes 2,3 of word 1 with 00 before DUMP. Without the macro: DUMP follows the 6th write immediately.
- filt_req held while res_valid=1 in STORE:
  - res_ready=0 that cycle.
  - Next cycle: mem_read=1, mem_M=filt_base=8'h20, filt_ack=1.
  - The stream then resumes at the correct offset.
- num_bytes=520 (DEPTH=128): byte 513 is refused, overflow=1, and res_ready stays 0.
- start with num_bytes=0: DUMP follows in 1 cycle, then done. No mem_write.
- rst_n low mid-STORE after 3 bytes:
  - All outputs 0 immediately.
  - Next start writes from address 0, offset 0.

Source files
------------

// File: rtl/out_mem_ctrl.sv
// out_mem_ctrl: packs PE result bytes four per output word, issues filter-block loads
// and the final dump. Define OUT_MEM_CTRL_ZERO_PAD_EN to zero-fill the last partial word.
module out_mem_ctrl #(
  parameter int DEPTH        = 128,
  parameter int FILTER_WORDS = 16
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_bytes,
  input  logic        res_valid,
  input  logic [7:0]  res_data,
  output logic        res_ready,
  input  logic        filt_req,
  input  logic [7:0]  filt_base,
  output logic        filt_ack,
  input  logic        host_rd,
  input  logic [7:0]  host_addr,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_writeOut,
  output logic        mem_load,
  output logic [7:0]  mem_address,
  output logic [7:0]  mem_M,
  output logic [1:0]  mem_offset,
  output logic [7:0]  mem_in,
  output logic        busy,
  output logic        done,
  output logic        overflow
);
  localparam int PW = $clog2(DEPTH + 1);

  if (FILTER_WORDS > DEPTH) begin : g_cfg_check
    $error("out_mem_ctrl: FILTER_WORDS exceeds DEPTH");
  end

`ifdef OUT_MEM_CTRL_ZERO_PAD_EN
  typedef enum logic [2:0] {IDLE, STORE, PAD, FILT, DUMP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, STORE, FILT, DUMP, DONE} state_t;
`endif

  state_t        state, state_n;
  logic [15:0]   cnt, nbytes;
  logic [PW-1:0] wptr;
  logic [1:0]    off, off_q;
  logic          ovf, wr_q;
  logic [7:0]    addr_q, din_q, m_q;
  logic          accept, full, last;

  assign full     = (wptr == PW'(DEPTH));
  assign last     = (cnt == nbytes);
  assign accept   = res_valid && res_ready;
  assign overflow = ovf;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    res_ready = 1'b0;
    case (state)
      IDLE: if (start) state_n = (num_bytes == 16'd0) ? DUMP : STORE;
      STORE: begin
        // filter loads win over results; ready drops in the same cycle
        res_ready = !filt_req && !ovf && !full && !last;
        if (filt_req) state_n = FILT;
        else if (last) begin
`ifdef OUT_MEM_CTRL_ZERO_PAD_EN
          state_n = (off != 2'd0) ? PAD : DUMP;
`else
          state_n = DUMP;
`endif
        end
      end
`ifdef OUT_MEM_CTRL_ZERO_PAD_EN
      PAD:  if (off == 2'd3) state_n = DUMP;
`endif
      FILT: state_n = STORE;
      DUMP: state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      nbytes <= '0;
      wptr   <= '0;
      off    <= '0;
      ovf    <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      off_q  <= '0;
      din_q  <= '0;
      m_q    <= '0;
    end else begin
      wr_q <= accept;
      if (state == IDLE && start) begin
        cnt    <= '0;
        wptr   <= '0;
        off    <= '0;
        ovf    <= 1'b0;
        nbytes <= num_bytes;
      end
      if (accept) begin
        addr_q <= 8'(wptr);
        off_q  <= off;
        din_q  <= res_data;
        cnt    <= cnt + 16'd1;
        off    <= off + 2'd1;
        if (off == 2'd3) wptr <= wptr + PW'(1);
      end
      if (state == STORE && res_valid && full && !filt_req && !last) ovf <= 1'b1;
      if (state == STORE && filt_req) m_q <= filt_base;
`ifdef OUT_MEM_CTRL_ZERO_PAD_EN
      if (state == PAD) begin
        off <= off + 2'd1;
        if (off == 2'd3) wptr <= wptr + PW'(1);
      end
`endif
    end
  end

  always_comb begin
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    mem_writeOut = 1'b0;
    mem_load     = 1'b0;
    mem_address  = 8'h00;
    mem_M        = 8'h00;
    mem_offset   = 2'd0;
    mem_in       = 8'h00;
    filt_ack     = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        mem_load    = host_rd;
        mem_address = host_addr;
      end
`ifdef OUT_MEM_CTRL_ZERO_PAD_EN
      // pad lanes go out straight from the pointer, so DUMP never overlaps a write
      PAD: begin
        mem_write   = 1'b1;
        mem_address = 8'(wptr);
        mem_offset  = off;
      end
`endif
      FILT: begin
        mem_read = 1'b1;
        filt_ack = 1'b1;
        mem_M    = m_q;
      end
      DUMP: mem_writeOut = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
    if (wr_q) begin
      mem_write   = 1'b1;
      mem_address = addr_q;
      mem_offset  = off_q;
      mem_in      = din_q;
    end
  end
endmodule

// File: tb/tb_out_mem_ctrl.sv
// Directed vector bench for out_mem_ctrl: table of per-cycle stimulus and expected outputs.
module tb_out_mem_ctrl;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n, start, res_valid, filt_req, host_rd;
  logic [15:0] num_bytes;
  logic [7:0]  res_data, filt_base, host_addr;
  logic        res_ready, filt_ack, mem_write, mem_read, mem_writeOut, mem_load;
  logic        busy, done, overflow;
  logic [7:0]  mem_address, mem_M, mem_in;
  logic [1:0]  mem_offset;
  logic [34:0] outs;

  out_mem_ctrl dut (
    .clock(clock), .rst_n(rst_n), .start(start), .num_bytes(num_bytes),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .filt_req(filt_req), .filt_base(filt_base), .filt_ack(filt_ack),
    .host_rd(host_rd), .host_addr(host_addr),
    .mem_write(mem_write), .mem_read(mem_read), .mem_writeOut(mem_writeOut),
    .mem_load(mem_load), .mem_address(mem_address), .mem_M(mem_M),
    .mem_offset(mem_offset), .mem_in(mem_in),
    .busy(busy), .done(done), .overflow(overflow)
  );

  assign outs = {res_ready, mem_write, mem_read, mem_writeOut, mem_load, mem_address,
                 mem_offset, mem_in, mem_M, filt_ack, busy, done, overflow};

  typedef struct {
    logic        st;
    logic [15:0] nb;
    logic        rv;
    logic [7:0]  rd;
    logic        fr;
    logic [7:0]  fb;
    logic        hr;
    logic [7:0]  ha;
    logic [34:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;
  int   acc;

  function automatic logic [34:0] ex(input logic rdy, wr, rdc, wo, ld,
                                     input logic [7:0] addr, input logic [1:0] off,
                                     input logic [7:0] din, m,
                                     input logic ack, bsy, dn, ovf);
    return {rdy, wr, rdc, wo, ld, addr, off, din, m, ack, bsy, dn, ovf};
  endfunction

  function automatic logic [34:0] ZX();
    return ex(0, 0, 0, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0);
  endfunction
  function automatic logic [34:0] SX(input logic rdy);
    return ex(rdy, 0, 0, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 1, 0, 0);
  endfunction
  function automatic logic [34:0] WX(input logic rdy, input logic [7:0] a,
                                     input logic [1:0] o, input logic [7:0] d);
    return ex(rdy, 1, 0, 0, 0, a, o, d, 8'h00, 0, 1, 0, 0);
  endfunction
  function automatic logic [34:0] DUMPX();
    return ex(0, 0, 0, 1, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 1, 0, 0);
  endfunction
  function automatic logic [34:0] DONEX();
    return ex(0, 0, 0, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 1, 1, 0);
  endfunction

  function automatic vec_t mk(input logic st, input logic [15:0] nb, input logic rv,
                              input logic [7:0] rd, input logic fr, input logic [7:0] fb,
                              input logic [34:0] e, input string nm);
    vec_t v;
    v.st = st; v.nb = nb; v.rv = rv; v.rd = rd; v.fr = fr; v.fb = fb;
    v.hr = 1'b0; v.ha = 8'h00; v.exp = e; v.name = nm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive at posedge+1, sample at negedge, return at next posedge+1
  task automatic apply(input vec_t v);
    start = v.st; num_bytes = v.nb; res_valid = v.rv; res_data = v.rd;
    filt_req = v.fr; filt_base = v.fb; host_rd = v.hr; host_addr = v.ha;
    @(negedge clock);
    chk(v.name, outs, v.exp);
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    start = 0; num_bytes = 0; res_valid = 0; res_data = 0;
    filt_req = 0; filt_base = 0; host_rd = 0; host_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic byte_rows(input logic [7:0] base, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i == 0) tbl.push_back(mk(0, 0, 1, base, 0, 0, SX(1), $sformatf("%s_b0", tag)));
      else tbl.push_back(mk(0, 0, 1, 8'(base + 8'(i)), 0, 0,
                            WX(1, 8'((i - 1) / 4), 2'((i - 1) % 4), 8'(base + 8'(i - 1))),
                            $sformatf("%s_b%0d", tag, i)));
    end
  endtask

  initial begin
    vec_t r;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clock);
    chk("reset_state", outs, ZX());
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;

    // host readback in IDLE
    r = mk(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 8'h33, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0), "host_rd");
    r.hr = 1'b1; r.ha = 8'h33;
    tbl.push_back(r);

    // 8 bytes back-to-back
    tbl.push_back(mk(1, 16'd8, 0, 0, 0, 0, ZX(), "b8_start"));
    byte_rows(8'h11, 8, "b8");
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, WX(0, 8'h01, 2'd3, 8'h18), "b8_last_wr"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DUMPX(), "b8_dump"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DONEX(), "b8_done"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, ZX(), "b8_idle"));

    // empty layer
    tbl.push_back(mk(1, 16'd0, 0, 0, 0, 0, ZX(), "n0_start"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DUMPX(), "n0_dump"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DONEX(), "n0_done"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, ZX(), "n0_idle"));

    // filter request pre-empts the stream
    tbl.push_back(mk(1, 16'd4, 0, 0, 0, 0, ZX(), "f_start"));
    tbl.push_back(mk(0, 0, 1, 8'hA1, 0, 0, SX(1), "f_b0"));
    tbl.push_back(mk(0, 0, 1, 8'hA2, 1, 8'h20, WX(0, 8'h00, 2'd0, 8'hA1), "f_req"));
    tbl.push_back(mk(0, 0, 1, 8'hA2, 0, 0,
                     ex(0, 0, 1, 0, 0, 8'h00, 2'd0, 8'h00, 8'h20, 1, 1, 0, 0), "f_ack"));
    tbl.push_back(mk(0, 0, 1, 8'hA2, 0, 0, SX(1), "f_resume"));
    tbl.push_back(mk(0, 0, 1, 8'hA3, 0, 0, WX(1, 8'h00, 2'd1, 8'hA2), "f_b2"));
    tbl.push_back(mk(0, 0, 1, 8'hA4, 0, 0, WX(1, 8'h00, 2'd2, 8'hA3), "f_b3"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, WX(0, 8'h00, 2'd3, 8'hA4), "f_last_wr"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DUMPX(), "f_dump"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DONEX(), "f_done"));

    // 6 bytes: partial last word
    tbl.push_back(mk(1, 16'd6, 0, 0, 0, 0, ZX(), "b6_start"));
    byte_rows(8'h61, 6, "b6");
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, WX(0, 8'h01, 2'd1, 8'h66), "b6_last_wr"));
`ifdef OUT_MEM_CTRL_ZERO_PAD_EN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, WX(0, 8'h01, 2'd2, 8'h00), "b6_pad2"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, WX(0, 8'h01, 2'd3, 8'h00), "b6_pad3"));
`endif
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DUMPX(), "b6_dump"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, DONEX(), "b6_done"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, ZX(), "b6_idle"));

    foreach (tbl[i]) apply(tbl[i]);

    // overflow: 520 bytes into 128 words
    apply(mk(1, 16'd520, 0, 0, 0, 0, ZX(), "o_start"));
    acc = 0;
    for (int c = 0; c < 700 && acc < 512; c++) begin
      start = 0; num_bytes = 0; res_valid = 1; res_data = 8'(acc);
      @(negedge clock);
      if (res_ready) acc++;
      @(posedge clock); #1;
    end
    chk("o_accepted", 35'(acc), 35'd512);
    @(negedge clock);
    chk("o_last_wr", outs, WX(0, 8'h7F, 2'd3, 8'hFF));
    @(posedge clock); #1;
    @(negedge clock);
    chk("o_refused", outs, ex(0, 0, 0, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1));
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("o_stall", outs, ex(0, 0, 0, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1));

    // reset mid-STORE, then a fresh layer starts at word 0 lane 0
    @(posedge clock); #1;
    do_reset();
    apply(mk(1, 16'd8, 0, 0, 0, 0, ZX(), "r_start"));
    apply(mk(0, 0, 1, 8'hC1, 0, 0, SX(1), "r_b0"));
    apply(mk(0, 0, 1, 8'hC2, 0, 0, WX(1, 8'h00, 2'd0, 8'hC1), "r_b1"));
    apply(mk(0, 0, 1, 8'hC3, 0, 0, WX(1, 8'h00, 2'd1, 8'hC2), "r_b2"));
    res_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("r_async", outs, ZX());
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    apply(mk(1, 16'd2, 0, 0, 0, 0, ZX(), "r2_start"));
    apply(mk(0, 0, 1, 8'hD1, 0, 0, SX(1), "r2_b0"));
    apply(mk(0, 0, 1, 8'hD2, 0, 0, WX(1, 8'h00, 2'd0, 8'hD1), "r2_b1"));
    apply(mk(0, 0, 0, 0, 0, 0, WX(0, 8'h00, 2'd1, 8'hD2), "r2_last_wr"));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
